// File: rtl/pack_pkg.sv
// Header layout and FSM encoding shared by the frame packer and unpacker so
// both ends of the link decode the instruction beat identically.
package pack_pkg;

    localparam int DATAWIDTH_DEF = 512;
    localparam int LEN_W_DEF     = 16;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SAVE = 2'b10;

    // Opcode sits in the top two bits, the beat count directly below it.
    localparam int OPC_HI = DATAWIDTH_DEF - 1;
    localparam int LEN_HI = DATAWIDTH_DEF - 3;
    localparam int LEN_LO = DATAWIDTH_DEF - 2 - LEN_W_DEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/unpack_if.sv
// Frame input stream, instruction outputs and forwarded data stream of the
// unpacker; the slave side is the unpacker itself.
interface unpack_if #(
    parameter int LOAD_INS_LEN = 96,
    parameter int SAVE_INS_LEN = 128,
    parameter int DATAWIDTH    = 512
);

    logic                    frame_valid;
    logic                    frame_ready;
    logic [DATAWIDTH-1:0]    frame_data;
    logic [LOAD_INS_LEN-1:0] load_ins_data;
    logic                    load_ins_valid;
    logic [SAVE_INS_LEN-1:0] save_ins_data;
    logic                    save_ins_valid;
    logic [DATAWIDTH-1:0]    data;
    logic                    data_valid;
    logic                    data_ready;
    logic                    data_last;
    logic                    done;
    logic                    error;

    modport master (
        output frame_valid, frame_data, data_ready,
        input  frame_ready, load_ins_data, load_ins_valid, save_ins_data,
               save_ins_valid, data, data_valid, data_last, done, error
    );

    modport slave (
        input  frame_valid, frame_data, data_ready,
        output frame_ready, load_ins_data, load_ins_valid, save_ins_data,
               save_ins_valid, data, data_valid, data_last, done, error
    );

endinterface

// File: rtl/frame_out_stage.sv
// One-entry valid/ready register holding a data beat and its last flag;
// it accepts a new beat whenever it is empty or being drained this cycle.
module frame_out_stage #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/unpack.sv
// Receive-side frame unpacker: decodes one instruction header per packet,
// then forwards or discards its data beats through a one-entry output stage.
module unpack
    import pack_pkg::*;
#(
    parameter int LOAD_INS_LEN = 96,
    parameter int SAVE_INS_LEN = 128,
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int LEN_W        = LEN_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    unpack_if.slave  bus
);

    logic [1:0]              state;
    logic [LEN_W-1:0]        remaining;
    logic [1:0]              opcode;
    logic [LEN_W-1:0]        len;
    logic                    frame_ready;
    logic                    accept;
    logic                    stage_in_valid;
    logic                    stage_in_ready;
    logic                    stage_in_last;
    logic                    out_valid;
    logic                    out_last;
    logic [DATAWIDTH-1:0]    out_data;
    logic                    last_handshake;
    logic [LOAD_INS_LEN-1:0] load_ins_data;
    logic                    load_ins_valid;
    logic [SAVE_INS_LEN-1:0] save_ins_data;
    logic                    save_ins_valid;
    logic                    error;

    assign opcode = bus.frame_data[DATAWIDTH-1 -: 2];
    assign len    = bus.frame_data[DATAWIDTH-3 -: LEN_W];

    // A zero remaining count in DATA means the packet is fully consumed and
    // we are only waiting for the last beat to drain downstream.
    always_comb begin
        frame_ready = 1'b0;
        case (state)
            ST_IDLE: frame_ready = 1'b1;
            ST_DROP: frame_ready = 1'b1;
            ST_DATA: frame_ready = (remaining != '0) && stage_in_ready;
            default: frame_ready = 1'b0;
        endcase
    end

    assign accept         = bus.frame_valid && frame_ready;
    assign stage_in_valid = accept && (state == ST_DATA);
    assign stage_in_last  = (remaining == LEN_W'(1));
    assign last_handshake = out_valid && bus.data_ready && out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            remaining      <= '0;
            load_ins_data  <= '0;
            load_ins_valid <= 1'b0;
            save_ins_data  <= '0;
            save_ins_valid <= 1'b0;
            error          <= 1'b0;
        end else begin
            load_ins_valid <= 1'b0;
            save_ins_valid <= 1'b0;
            error          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        remaining <= len;
                        case (opcode)
                            OP_LOAD: begin
                                load_ins_data  <= bus.frame_data[LOAD_INS_LEN-1:0];
                                load_ins_valid <= 1'b1;
                                state          <= (len == '0) ? ST_DONE : ST_DATA;
                            end
                            OP_SAVE: begin
                                save_ins_data  <= bus.frame_data[SAVE_INS_LEN-1:0];
                                save_ins_valid <= 1'b1;
                                state          <= (len == '0) ? ST_DONE : ST_DATA;
                            end
                            default: begin
                                error <= 1'b1;
                                state <= (len == '0) ? ST_IDLE : ST_DROP;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                    end
                    if (last_handshake) begin
                        state <= ST_DONE;
                    end
                end
                ST_DROP: begin
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    frame_out_stage #(
        .W (DATAWIDTH)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (stage_in_valid),
        .in_data   (bus.frame_data),
        .in_last   (stage_in_last),
        .in_ready  (stage_in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (bus.data_ready)
    );

    assign bus.frame_ready    = frame_ready;
    assign bus.load_ins_data  = load_ins_data;
    assign bus.load_ins_valid = load_ins_valid;
    assign bus.save_ins_data  = save_ins_data;
    assign bus.save_ins_valid = save_ins_valid;
    assign bus.error          = error;
    assign bus.done           = (state == ST_DONE);
    assign bus.data           = out_data;
    assign bus.data_valid     = out_valid;
    assign bus.data_last      = out_last;

endmodule

// File: tb/tb_unpack.sv
// Randomized bench for the unpacker: packets are built as beat streams and the
// outputs are predicted by a packet-level model with a queue of pending beats.
module tb_unpack;
    import pack_pkg::*;

    localparam int PH_HDR  = 0;
    localparam int PH_DATA = 1;
    localparam int PH_DROP = 2;
    localparam int PH_DONE = 3;

    typedef struct {
        logic [511:0] d;
        logic         last;
    } beat_t;

    logic clk;
    logic rst;

    unpack_if bus ();

    unpack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors;
    int miscompares;
    int cyc;
    int fv_prob;
    int dr_mode;

    logic [511:0] stream[$];
    beat_t        pend[$];
    int           phase;
    int           left;
    logic         exp_load_v;
    logic         exp_save_v;
    logic         exp_err;
    logic [95:0]  mdl_load;
    logic [127:0] mdl_save;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void addPacket(input logic [1:0] opc, input int len, input logic [127:0] payload);
        logic [511:0] hdr;
        hdr = rand512();
        hdr[OPC_HI -: 2]    = opc;
        hdr[LEN_HI:LEN_LO]  = 16'(len);
        hdr[127:0]          = payload;
        stream.push_back(hdr);
        for (int i = 0; i < len; i++) stream.push_back(rand512());
    endfunction

    function automatic void resetModel();
        stream.delete();
        pend.delete();
        phase      = PH_HDR;
        left       = 0;
        exp_load_v = 1'b0;
        exp_save_v = 1'b0;
        exp_err    = 1'b0;
        mdl_load   = '0;
        mdl_save   = '0;
    endfunction

    // One clock cycle: drive inputs, compare every output with the model, then
    // advance the model by whatever transfers the upcoming edge performs.
    task automatic stepCycle();
        logic         acc;
        logic         hs;
        logic         exp_ready;
        logic [511:0] beat;
        logic [1:0]   opc;
        logic [15:0]  hl;
        int           nphase;

        @(negedge clk);
        cyc++;
        case (dr_mode)
            0:       bus.data_ready = 1'b1;
            2:       bus.data_ready = (cyc % 3 == 0);
            default: bus.data_ready = 1'($urandom_range(1));
        endcase
        if (stream.size() != 0 && $urandom_range(99) < fv_prob) begin
            bus.frame_valid = 1'b1;
            bus.frame_data  = stream[0];
        end else begin
            bus.frame_valid = 1'b0;
            bus.frame_data  = rand512();
        end
        #1;

        case (phase)
            PH_HDR:  exp_ready = 1'b1;
            PH_DATA: exp_ready = (left > 0) && (pend.size() == 0 || bus.data_ready);
            PH_DROP: exp_ready = 1'b1;
            default: exp_ready = 1'b0;
        endcase
        checkOutput("frame_ready", bus.frame_ready, exp_ready);
        checkOutput("load_ins_valid", bus.load_ins_valid, exp_load_v);
        checkOutput("load_ins_data", bus.load_ins_data, mdl_load);
        checkOutput("save_ins_valid", bus.save_ins_valid, exp_save_v);
        checkOutput("save_ins_data", bus.save_ins_data, mdl_save);
        checkOutput("error", bus.error, exp_err);
        checkOutput("done", bus.done, phase == PH_DONE);
        checkOutput("data_valid", bus.data_valid, pend.size() != 0);
        if (pend.size() != 0) begin
            checkOutput("data", bus.data, pend[0].d);
            checkOutput("data_last", bus.data_last, pend[0].last);
        end

        acc        = bus.frame_valid && bus.frame_ready;
        hs         = (pend.size() != 0) && bus.data_ready;
        exp_load_v = 1'b0;
        exp_save_v = 1'b0;
        exp_err    = 1'b0;
        nphase     = phase;
        beat       = '0;
        if (acc) beat = stream.pop_front();

        case (phase)
            PH_HDR: begin
                if (acc) begin
                    opc  = beat[OPC_HI -: 2];
                    hl   = beat[LEN_HI:LEN_LO];
                    left = int'(hl);
                    if (opc == OP_LOAD) begin
                        exp_load_v = 1'b1;
                        mdl_load   = beat[95:0];
                        nphase     = (left == 0) ? PH_DONE : PH_DATA;
                    end else if (opc == OP_SAVE) begin
                        exp_save_v = 1'b1;
                        mdl_save   = beat[127:0];
                        nphase     = (left == 0) ? PH_DONE : PH_DATA;
                    end else begin
                        exp_err = 1'b1;
                        nphase  = (left == 0) ? PH_HDR : PH_DROP;
                    end
                end
            end
            PH_DATA: begin
                if (hs) begin
                    if (pend[0].last) nphase = PH_DONE;
                    void'(pend.pop_front());
                end
                if (acc) begin
                    pend.push_back('{d: beat, last: (left == 1)});
                    left--;
                end
            end
            PH_DROP: begin
                if (acc) begin
                    left--;
                    if (left == 0) nphase = PH_HDR;
                end
            end
            default: nphase = PH_HDR;
        endcase
        if (phase != PH_DATA && hs) void'(pend.pop_front());
        phase = nphase;
    endtask

    task automatic applyStimulus();
        int   n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 4000) begin
            stepCycle();
            n++;
            busy = (stream.size() != 0) || (phase != PH_HDR) || (pend.size() != 0) ||
                   exp_load_v || exp_save_v || exp_err;
        end
        checkOutput("drain", busy, 1'b0);
    endtask

    initial begin
        int n;
        vectors          = 0;
        miscompares      = 0;
        cyc              = 0;
        fv_prob          = 100;
        dr_mode          = 0;
        rst              = 1'b1;
        bus.frame_valid  = 1'b0;
        bus.frame_data   = '0;
        bus.data_ready   = 1'b0;
        resetModel();

        #12;
        checkOutput("rst_frame_ready", bus.frame_ready, 1'b1);
        checkOutput("rst_data_valid", bus.data_valid, 1'b0);
        checkOutput("rst_data", bus.data, '0);
        checkOutput("rst_done", bus.done, 1'b0);
        checkOutput("rst_error", bus.error, 1'b0);
        checkOutput("rst_load_data", bus.load_ins_data, '0);
        checkOutput("rst_save_data", bus.save_ins_data, '0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] load packet, two beats");
        addPacket(OP_LOAD, 2, {32'h0, {12{8'hA5}}});
        applyStimulus();

        $display("[TB] save packet, zero beats");
        addPacket(OP_SAVE, 0, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus();

        $display("[TB] four beats with stalled downstream");
        dr_mode = 2;
        addPacket(OP_LOAD, 4, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus();

        $display("[TB] invalid opcode then load");
        dr_mode = 0;
        addPacket(2'b11, 3, {$urandom, $urandom, $urandom, $urandom});
        addPacket(OP_LOAD, 1, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus();

        $display("[TB] reset mid-packet");
        addPacket(OP_LOAD, 5, {$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (!(phase == PH_DATA && left <= 3) && n < 100) begin
            stepCycle();
            n++;
        end
        checkOutput("reach_mid_packet", left, 3);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_data_valid", bus.data_valid, 1'b0);
        checkOutput("arst_data", bus.data, '0);
        checkOutput("arst_data_last", bus.data_last, 1'b0);
        checkOutput("arst_load_valid", bus.load_ins_valid, 1'b0);
        checkOutput("arst_load_data", bus.load_ins_data, '0);
        checkOutput("arst_done", bus.done, 1'b0);
        checkOutput("arst_frame_ready", bus.frame_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        addPacket(OP_SAVE, 2, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus();

        $display("[TB] back-to-back packets");
        addPacket(OP_LOAD, 1, {$urandom, $urandom, $urandom, $urandom});
        addPacket(OP_SAVE, 1, {$urandom, $urandom, $urandom, $urandom});
        applyStimulus();

        $display("[TB] random packets");
        dr_mode = 1;
        for (int p = 0; p < 60; p++) begin
            fv_prob = 50 + $urandom_range(50);
            addPacket(2'($urandom_range(3)), $urandom_range(6),
                      {$urandom, $urandom, $urandom, $urandom});
        end
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
